ai_vector_mac_engine: RTL
=========================

Name: ai_vector_mac_engine

Overview:
Parametrised multi-cycle vector multiply-accumulate engine for the EX-stage AI path. It replaces the fixed single-operand matrix multiplier and its controller FSM with one block. A command (op, length, shift) is accepted, then LEN beats of packed signed operand vectors are streamed in and reduced to one accumulator. The result goes through a selectable post-process and is held on a valid/ready output. `busy` drives the pipeline stall.

Parameters:
LANES, 4, elements per beat
EW, 8, signed element width in bits
ACC_W, 32, accumulator/result width
LEN_W, 5, width of beat-count field; max length 2^LEN_W-1

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  engine can take a command (IDLE only)
cmd_op  input  2  00 DOT-wrap, 01 DOT-sat, 10 DOT-sat+ReLU, 11 DOT-sat+shift
cmd_len  input  LEN_W  number of beats
cmd_shift  input  5  arithmetic right shift amount (op 11)
in_valid  input  1  operand beat present
in_ready  output  1  engine accepts beat (ACCUM only)
in_a  input  LANES*EW  packed signed vector A, lane 0 in LSBs
in_b  input  LANES*EW  packed signed vector B
abort  input  1  synchronous cancel
out_valid  output  1  result held
out_ready  input  1  consumer takes result
out_data  output  ACC_W  result
busy  output  1  high in every state except IDLE; pipeline stall request

Behaviour:
- Reset (reset=0, async): state IDLE, acc=0, beat counter=0. Outputs: cmd_ready=1, in_ready=0, out_valid=0, out_data=0, busy=0.
- States: IDLE, ACCUM, POST, DONE.
- IDLE -> ACCUM on cmd_valid&cmd_ready. op/len/shift are latched and acc is cleared. If cmd_len=0, go IDLE -> POST directly (result 0).
- ACCUM:
  - in_ready=1. A beat is taken on in_valid&in_ready.
  - beat_sum = sum over lanes of a[i]*b[i]. Each product is 2*EW signed. The sum is sign-extended, width 2*EW+clog2(LANES).
  - acc is updated at the clock edge that accepts the beat.
  - Op 00: acc = (acc + beat_sum) mod 2^ACC_W.
  - Ops 01/10/11: add at ACC_W+1 bits, then clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on every beat.
  - Counter increments per beat. After beat number len is accepted -> POST.
  - No beat is accepted beyond len.
- POST (exactly 1 cycle), result computed from acc:
  - 00/01: result = acc.
  - 10: result = acc<0 ? 0 : acc.
  - 11: result = acc >>> shift (sign-filling).
  - The result is registered into out_data and the state goes to DONE.
- DONE:
  - out_valid=1. out_data is held stable until out_ready.
  - On out_valid&out_ready -> IDLE with out_valid=0 on the next cycle. out_data keeps its last value.
- Latency: out_valid rises 2 cycles after the edge that accepts the final beat. For len=0 it rises 2 cycles after command accept.
- abort in ACCUM, POST or DONE: state is IDLE next cycle, acc and counter cleared, out_valid=0, no result is produced. abort in IDLE has no effect. abort takes priority over every other event in the same cycle.
- cmd_valid outside IDLE is ignored; cmd_ready=0.
- cmd_valid and a final out handshake in the same cycle: the command is not taken until the following cycle, in IDLE.
- in_valid outside ACCUM is ignored.
- Reset mid-operation: immediate return to reset values. The partial result is discarded.
- busy = (state != IDLE). It is combinational from the state register.

Decomposition:
- Shared package ai_pkg:
  - op encodings AI_OP_DOT_WRAP/DOT_SAT/DOT_RELU/DOT_SHIFT;
  - state enum ai_mac_state_t;
  - saturate function sat_acc(value, ACC_W).
- One sub-module, ai_lane_reduce: purely combinational, LANES multipliers plus adder tree, parametrised by LANES and EW, producing beat_sum.
- FSM, counter, accumulator and post-process stay in the top module.

Test Plan (LANES=4, EW=8, ACC_W=32 unless stated):
- Basic DOT-wrap: cmd len=1, a={1,2,3,4}, b={5,6,7,8} -> out_data=70, out_valid 2 cycles after the beat; busy high from the cycle after cmd accept until out handshake.
- Multi-beat with gaps and backpressure:
  - len=3, beats {1,1,1,1}·{2,2,2,2} (in_valid toggled 1/0), 3 beats total;
  - out_ready held low 5 cycles;
  - expect out_data=24, stable for all 5 cycles, then IDLE.
- Saturation:
  - ACC_W=16, op 01, len=4, a=b={-128 x4} (beat_sum=65536) -> result 32767;
  - the same with op 00 -> result 0 (wrap).
- ReLU and shift:
  - op 10, a={-3,0,0,0}, b={5,0,0,0} -> 0.
  - op 11, shift=2, a={-7,0,0,0}, b={3,0,0,0} -> -21>>>2 = -6.
- len=0 and ignored inputs:
  - cmd len=0 -> out_data=0 after 2 cycles;
  - in_valid pulses while in DONE do not change out_data;
  - a second cmd_valid while busy is not taken.
- Abort/reset:
  - abort asserted on beat 2 of len=4 -> IDLE next cycle, no out_valid;
  - a new cmd len=1 of 70 yields exactly 70 (no residue);
  - reset pulsed low in DONE -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ai_pkg.sv
// Shared types and helpers for the AI vector multiply-accumulate engine.
// Op encodings, FSM state type, and accumulator saturation.
package ai_pkg;

  typedef enum logic [1:0] {
    AI_OP_DOT_WRAP  = 2'b00,
    AI_OP_DOT_SAT   = 2'b01,
    AI_OP_DOT_RELU  = 2'b10,
    AI_OP_DOT_SHIFT = 2'b11
  } ai_op_t;

  typedef enum logic [1:0] {
    AI_ST_IDLE,
    AI_ST_ACCUM,
    AI_ST_POST,
    AI_ST_DONE
  } ai_mac_state_t;

  localparam int AI_SAT_W = 64;

  // Clamp a wide signed value into the signed range of an acc_w-bit register.
  function automatic logic signed [AI_SAT_W-1:0] sat_acc(
    input logic signed [AI_SAT_W-1:0] value,
    input int                         acc_w
  );
    logic signed [AI_SAT_W-1:0] v_max;
    logic signed [AI_SAT_W-1:0] v_min;
    v_max = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    v_min = -v_max - 64'sd1;
    if (value > v_max) return v_max;
    if (value < v_min) return v_min;
    return value;
  endfunction

endpackage

// File: rtl/ai_lane_reduce.sv
// Combinational lane reduction: signed element-wise products of two packed
// vectors summed into one sign-extended beat sum.
module ai_lane_reduce
  import ai_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int SUM_W = 2 * EW + $clog2(LANES)
) (
  input  logic [LANES*EW-1:0]     i_a,
  input  logic [LANES*EW-1:0]     i_b,
  output logic signed [SUM_W-1:0] o_sum
);

  localparam int PW = 2 * EW;

  logic signed [PW-1:0]    w_prod [LANES];
  logic signed [SUM_W-1:0] w_tree;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PW-1:0] w_ea;
    logic signed [PW-1:0] w_eb;
    assign w_ea      = PW'(signed'(i_a[g*EW +: EW]));
    assign w_eb      = PW'(signed'(i_b[g*EW +: EW]));
    assign w_prod[g] = w_ea * w_eb;
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < LANES; i++) begin
      w_tree = w_tree + SUM_W'(w_prod[i]);
    end
  end

  assign o_sum = w_tree;

endmodule

// File: rtl/ai_vector_mac_engine.sv
// Multi-cycle vector MAC engine: takes a command, reduces LEN operand beats
// into one accumulator, post-processes it and holds the result on valid/ready.
module ai_vector_mac_engine
  import ai_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [1:0]          i_cmd_op,
  input  logic [LEN_W-1:0]    i_cmd_len,
  input  logic [4:0]          i_cmd_shift,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [LANES*EW-1:0] i_in_a,
  input  logic [LANES*EW-1:0] i_in_b,
  input  logic                i_abort,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [ACC_W-1:0]    o_out_data,
  output logic                o_busy
);

  localparam int SUM_W  = 2 * EW + $clog2(LANES);
  localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
  localparam int CW     = LEN_W + 1;

  ai_mac_state_t           r_state;
  ai_mac_state_t           w_state_nxt;
  ai_op_t                  r_op;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_cnt;
  logic [4:0]              r_shift;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_data;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_result;
  logic signed [SUM_W-1:0] w_beat_sum;
  logic signed [WIDE_W-1:0] w_wide_sum;
  logic                    w_cmd_take;
  logic                    w_beat_take;
  logic                    w_last_beat;
  logic                    w_abort;

  ai_lane_reduce #(
    .LANES (LANES),
    .EW    (EW)
  ) u_lane_reduce (
    .i_a   (i_in_a),
    .i_b   (i_in_b),
    .o_sum (w_beat_sum)
  );

  assign w_abort     = i_abort && (r_state != AI_ST_IDLE);
  assign w_cmd_take  = (r_state == AI_ST_IDLE) && i_cmd_valid;
  assign w_beat_take = (r_state == AI_ST_ACCUM) && i_in_valid;
  assign w_last_beat = (CW'(r_cnt) + CW'(1)) == CW'(r_len);

  // Headroom above both operands so the saturating path sees the true sum.
  assign w_wide_sum = WIDE_W'(r_acc) + WIDE_W'(w_beat_sum);
  assign w_acc_nxt  = (r_op == AI_OP_DOT_WRAP)
                    ? ACC_W'(w_wide_sum)
                    : ACC_W'(sat_acc(AI_SAT_W'(w_wide_sum), ACC_W));

  always_comb begin
    w_result = r_acc;
    case (r_op)
      AI_OP_DOT_RELU:  if (r_acc < 0) w_result = '0;
      AI_OP_DOT_SHIFT: w_result = r_acc >>> r_shift;
      default:         w_result = r_acc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      AI_ST_IDLE: begin
        if (w_cmd_take) begin
          w_state_nxt = (i_cmd_len == '0) ? AI_ST_POST : AI_ST_ACCUM;
        end
      end
      AI_ST_ACCUM: if (w_beat_take && w_last_beat) w_state_nxt = AI_ST_POST;
      AI_ST_POST:  w_state_nxt = AI_ST_DONE;
      AI_ST_DONE:  if (i_out_ready) w_state_nxt = AI_ST_IDLE;
      default:     w_state_nxt = AI_ST_IDLE;
    endcase
    if (w_abort) w_state_nxt = AI_ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= AI_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Abort wipes partial work but leaves the last delivered result visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op       <= AI_OP_DOT_WRAP;
      r_len      <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
    end else if (w_abort) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      if (w_cmd_take) begin
        r_op    <= ai_op_t'(i_cmd_op);
        r_len   <= i_cmd_len;
        r_shift <= i_cmd_shift;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (w_beat_take) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + LEN_W'(1);
      end
      if (r_state == AI_ST_POST) begin
        r_out_data <= w_result;
      end
    end
  end

  assign o_cmd_ready = (r_state == AI_ST_IDLE);
  assign o_in_ready  = (r_state == AI_ST_ACCUM);
  assign o_out_valid = (r_state == AI_ST_DONE);
  assign o_busy      = (r_state != AI_ST_IDLE);
  assign o_out_data  = r_out_data;

endmodule
